// File: rtl/seq_binary_multiplier_if.sv
// ---------------------------------------------------------------------------
// seq_binary_multiplier_if
//   Request/response bundle for the sequential shift-and-add multiplier.
//   Macro SEQ_MULT_SIGNED_EN adds the is_signed request bit.
//
//   start     : request, honoured only while busy=0
//   A, B      : multiplicand / multiplier, captured on accept
//   is_signed : (SEQ_MULT_SIGNED_EN only) treat A, B as two's complement
//   busy      : multiplication in progress
//   done      : one-cycle pulse, P is valid and new
//   P         : product, held until the next completion
//
//   master : requester side      slave : multiplier side
// ---------------------------------------------------------------------------
interface seq_binary_multiplier_if #(
  parameter int WIDTH = 4
) ();
  logic                 start;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   P;
`ifdef SEQ_MULT_SIGNED_EN
  logic                 is_signed;

  modport master (output start, A, B, is_signed, input  busy, done, P);
  modport slave  (input  start, A, B, is_signed, output busy, done, P);
`else
  modport master (output start, A, B, input  busy, done, P);
  modport slave  (input  start, A, B, output busy, done, P);
`endif
endinterface

// File: rtl/seq_binary_multiplier.sv
// ---------------------------------------------------------------------------
// seq_binary_multiplier
//   Unsigned WIDTH x WIDTH shift-and-add multiplier: one partial product per
//   clock through a single shared 2*WIDTH adder. An operation occupies WIDTH
//   RUN cycles followed by one DONE cycle; a start seen in DONE is accepted
//   immediately, so back-to-back throughput is one result per WIDTH+1 cycles.
//
//   Macro SEQ_MULT_SIGNED_EN : adds bus.is_signed. Signed operands are turned
//   into magnitudes at capture and the product is negated on entry to DONE.
//
//   Ports:
//     clk   : rising-edge clock
//     reset : asynchronous, active-high reset
//     bus   : seq_binary_multiplier_if.slave (start/A/B in, busy/done/P out)
// ---------------------------------------------------------------------------
module seq_binary_multiplier #(
  parameter int WIDTH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  seq_binary_multiplier_if.slave  bus
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            accept;
  logic            last_step;

  logic [PW-1:0]    mcand;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    acc_sum;
  logic [PW-1:0]    p_final;
  logic [PW-1:0]    p_q;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] a_cap;
  logic [WIDTH-1:0] b_cap;
  logic [CW-1:0]    cnt;
`ifdef SEQ_MULT_SIGNED_EN
  logic             neg;
  logic             neg_cap;
`endif

  // -------------------------------------------------------------------------
  // Control FSM
  // -------------------------------------------------------------------------
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  assign last_step = (cnt == CW'(WIDTH - 1));

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_step) state_next = DONE;
      end
      DONE: begin
        // A start here chains straight into the next operation.
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Operand conditioning and adder
  // -------------------------------------------------------------------------
  always_comb begin
`ifdef SEQ_MULT_SIGNED_EN
    // Signed operands are reduced to magnitudes; -2^(W-1) maps to 2^(W-1),
    // which still fits in WIDTH unsigned bits.
    a_cap   = (bus.is_signed && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    b_cap   = (bus.is_signed && bus.B[WIDTH-1]) ? -bus.B : bus.B;
    neg_cap = bus.is_signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
`else
    a_cap   = bus.A;
    b_cap   = bus.B;
`endif
  end

  assign acc_sum = acc + (mplier[0] ? mcand : '0);

`ifdef SEQ_MULT_SIGNED_EN
  assign p_final = neg ? -acc_sum : acc_sum;
`else
  assign p_final = acc_sum;
`endif

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      p_q    <= '0;
`ifdef SEQ_MULT_SIGNED_EN
      neg    <= 1'b0;
`endif
    end else if (accept) begin
      mcand  <= {{WIDTH{1'b0}}, a_cap};
      mplier <= b_cap;
      acc    <= '0;
      cnt    <= '0;
`ifdef SEQ_MULT_SIGNED_EN
      neg    <= neg_cap;
`endif
    end else if (state == RUN) begin
      // Fixed WIDTH steps even once mplier is exhausted: constant latency.
      acc    <= acc_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (last_step) p_q <= p_final;
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.P    = p_q;

endmodule

// File: tb/tb_seq_binary_multiplier.sv
// ---------------------------------------------------------------------------
// tb_seq_binary_multiplier
//   Scoreboard bench: each accepted request pushes its expected product and
//   the cycle its done pulse is due; a monitor pops and compares on done.
//   Build with +define+SEQ_MULT_SIGNED_EN to exercise signed operation.
// ---------------------------------------------------------------------------
module tb_seq_binary_multiplier;

  localparam int W = 4;

  typedef struct {
    logic [2*W-1:0] p;
    int             due;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;
  exp_t sb_q[$];

  seq_binary_multiplier_if #(.WIDTH(W)) bus ();

  seq_binary_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: integer product of the operands' values, truncated to 2W bits.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
    longint     sa;
    longint     sb;
    logic [63:0] prod;
    sa   = (s && a[W-1]) ? longint'(a) - (longint'(1) << W) : longint'(a);
    sb   = (s && b[W-1]) ? longint'(b) - (longint'(1) << W) : longint'(b);
    prod = sa * sb;
    return prod[2*W-1:0];
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (bus.done) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", bus.done, 1'b0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("product", bus.P, e.p);
        check("done_latency", cyc, e.due);
      end
    end
  end

  // Present a request; the push happens on the negedge whose following
  // posedge accepts it (busy low), so done is due W edges after that one.
  task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    exp_t e;
    int   guard;
    @(negedge clk);
    guard = 0;
    while (bus.busy && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
`ifdef SEQ_MULT_SIGNED_EN
    bus.is_signed = s;
`endif
    e.p   = ref_mul(a, b, s);
    e.due = cyc + 1 + W;
    sb_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.A     = W'($urandom);
    bus.B     = W'($urandom);
`ifdef SEQ_MULT_SIGNED_EN
    bus.is_signed = 1'($urandom);
`endif
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while (sb_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (sb_q.size() != 0) check("drain_timeout", sb_q.size(), 0);
  endtask

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: cycles 20000 required fewer");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   bc;
    exp_t e;
    checks    = 0;
    errors    = 0;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
`ifdef SEQ_MULT_SIGNED_EN
    bus.is_signed = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset_busy", bus.busy, 1'b0);
    check("reset_done", bus.done, 1'b0);
    check("reset_p",    bus.P,    '0);
    reset = 1'b0;

    // 3x3: busy for exactly W cycles, then P holds afterwards.
    op(4'd3, 4'd3, 1'b0);
    bc = 0;
    while (bus.busy && bc < 100) begin
      bc++;
      @(negedge clk);
    end
    check("busy_cycles", bc, W);
    repeat (3) @(negedge clk);
    check("p_hold", bus.P, ref_mul(4'd3, 4'd3, 1'b0));

    // Extremes and zero operands.
    op(4'd15, 4'd15, 1'b0);
    wait_drain();
    op(4'd0, 4'd13, 1'b0);
    wait_drain();
    op(4'd13, 4'd0, 1'b0);
    wait_drain();

    // start while busy is ignored.
    op(4'd5, 4'd6, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 4'd7;
    bus.B     = 4'd7;
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain();
    repeat (W + 3) @(negedge clk);

    // Back-to-back: start held, second operands shown in the DONE cycle.
    @(negedge clk);
    bus.start = 1'b1;
    bus.A     = 4'd2;
    bus.B     = 4'd3;
    e.p   = ref_mul(4'd2, 4'd3, 1'b0);
    e.due = cyc + 1 + W;
    sb_q.push_back(e);
    bc = 0;
    do begin
      @(negedge clk);
      bc++;
    end while (!bus.done && bc < 100);
    bus.A = 4'd4;
    bus.B = 4'd4;
    e.p   = ref_mul(4'd4, 4'd4, 1'b0);
    e.due = cyc + 1 + W;
    sb_q.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    wait_drain();
    repeat (2) @(negedge clk);

    // Reset in the second RUN cycle: immediate clear, no done afterwards.
    op(4'd9, 4'd9, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    sb_q.delete();
    #1;
    check("rst_run_busy", bus.busy, 1'b0);
    check("rst_run_done", bus.done, 1'b0);
    check("rst_run_p",    bus.P,    '0);
    @(negedge clk);
    reset = 1'b0;
    repeat (W + 3) @(negedge clk);
    op(4'd6, 4'd7, 1'b0);
    wait_drain();

`ifdef SEQ_MULT_SIGNED_EN
    op(4'b1101, 4'd5, 1'b1);
    wait_drain();
    op(4'b1000, 4'b1000, 1'b1);
    wait_drain();
    op(4'b1101, 4'd5, 1'b0);
    wait_drain();
`endif

    // Randomised traffic with random gaps (some land on the DONE cycle).
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
`ifdef SEQ_MULT_SIGNED_EN
      op(W'($urandom), W'($urandom), 1'($urandom));
`else
      op(W'($urandom), W'($urandom), 1'b0);
`endif
    end
    wait_drain();
    repeat (W + 3) @(negedge clk);
    check("queue_empty", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
